// File: rtl/display_pkg.sv
// Shared display-path types and constants for the count display: FSM states and BCD digit geometry.
package display_pkg;
   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
   localparam int         BCD_W          = 4;
   localparam logic [3:0] ADD3_THRESH    = 4'd5;
   localparam int         DISPLAY_DIGITS = 4;
endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3_digit
   import display_pkg::*;
(
   input  logic [BCD_W-1:0] digit_in,
   output logic [BCD_W-1:0] digit_out
);
   assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + BCD_W'(3) : digit_in;
endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle; done pulses BIN_W cycles after start.
// Start is sampled only while idle; requests during a conversion are dropped, not queued.
module seq_bin_to_bcd
   import display_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = DISPLAY_DIGITS
)
(
   input  logic             clk_50MHz,
   input  logic             reset_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [BCD_W-1:0] bcd3,
   output logic [BCD_W-1:0] bcd2,
   output logic [BCD_W-1:0] bcd1,
   output logic [BCD_W-1:0] bcd0
);
   localparam int DIG_W  = BCD_W * DIGITS;
   localparam int SR_W   = DIG_W + BIN_W;
   localparam int ITER_W = $clog2(BIN_W + 1);
   localparam logic [DIG_W-1:0] MAX_VAL = DIG_W'(10**DIGITS - 1);

   if (BIN_W > DIG_W) begin : g_width_check
      $error("seq_bin_to_bcd: BIN_W must not exceed 4*DIGITS");
   end

   state_t            state;
   logic [SR_W-1:0]   sr;
   logic [ITER_W-1:0] iter;
   logic              ovf_pend;
   logic [DIG_W-1:0]  digits;
   logic [DIG_W-1:0]  adj;
   logic [DIG_W-1:0]  bin_ext;
   logic [SR_W-1:0]   sr_next;

   // Correction touches only the digit field; the binary tail shifts through untouched.
   for (genvar d = 0; d < DIGITS; d++) begin : g_add3
      bcd_add3_digit u_add3 (
         .digit_in  (sr[BIN_W + BCD_W*d +: BCD_W]),
         .digit_out (adj[BCD_W*d +: BCD_W])
      );
   end

   assign sr_next = {adj[DIG_W-2:0], sr[BIN_W-1:0], 1'b0};
   assign bin_ext = DIG_W'(bin_in);

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         sr       <= '0;
         iter     <= '0;
         ovf_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         digits   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sr       <= SR_W'(bin_in);
                  iter     <= '0;
                  ovf_pend <= (bin_ext > MAX_VAL);
                  busy     <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sr   <= sr_next;
               iter <= iter + ITER_W'(1);
               if (iter == ITER_W'(BIN_W - 1)) begin
                  // Out-of-range inputs clamp to all nines rather than showing wrapped digits.
                  digits   <= ovf_pend ? {DIGITS{BCD_W'(9)}} : sr_next[SR_W-1 -: DIG_W];
                  overflow <= ovf_pend;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bcd0 = digits[0*BCD_W +: BCD_W];
   assign bcd1 = digits[1*BCD_W +: BCD_W];
   assign bcd2 = digits[2*BCD_W +: BCD_W];
   assign bcd3 = digits[3*BCD_W +: BCD_W];
endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed bench for seq_bin_to_bcd: latency, back-to-back, clamp, ignored restart, mid-run reset.
module tb_seq_bin_to_bcd;
   logic        clk;
   logic        reset_n;
   logic        start;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [3:0]  bcd3, bcd2, bcd1, bcd0;

   int checks = 0;
   int errors = 0;

   seq_bin_to_bcd dut (
      .clk_50MHz (clk),
      .reset_n   (reset_n),
      .start     (start),
      .bin_in    (bin_in),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .bcd3      (bcd3),
      .bcd2      (bcd2),
      .bcd1      (bcd1),
      .bcd0      (bcd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int v);
      start  = 1'b1;
      bin_in = 14'(v);
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   function automatic logic [15:0] model(input int v);
      if (v > 9999) return 16'h9999;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(negedge clk) begin
      if (reset_n === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
         checks++;
         assert (!(busy === 1'b1 && done === 1'b1)) else begin
            errors++;
            $error("FAIL busy_done_overlap observed 1 expected 0");
         end
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ndone;
      int sweep [16] = '{0, 1, 9, 10, 99, 100, 999, 1000, 4096, 5555,
                         9998, 9999, 10000, 12345, 16382, 16383};

      reset_n = 1'b0;
      start   = 1'b0;
      bin_in  = '0;
      repeat (3) @(posedge clk);
      #4 reset_n = 1'b1;
      tick();

      // 1: reset state
      check("rst_digits", {bcd3, bcd2, bcd1, bcd0}, 32'h0000);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);

      // 2: basic conversion and latency
      launch(1234);
      check("t2_busy", busy, 1);
      wait_done(n);
      check("t2_latency", n, 14);
      check("t2_busy_at_done", busy, 0);
      check("t2_digits", {bcd3, bcd2, bcd1, bcd0}, 32'h1234);
      check("t2_ovf", overflow, 0);
      tick();
      check("t2_done_pulse", done, 0);
      check("t2_digits_held", {bcd3, bcd2, bcd1, bcd0}, 32'h1234);

      // 3: back-to-back, start raised in the done cycle
      launch(0);
      wait_done(n);
      check("t3_digits_0", {bcd3, bcd2, bcd1, bcd0}, 32'h0000);
      launch(9999);
      wait_done(n);
      check("t3_spacing", n + 1, 15);
      check("t3_digits_9999", {bcd3, bcd2, bcd1, bcd0}, 32'h9999);
      check("t3_ovf", overflow, 0);

      // 4: clamp on overflow, then recovery
      launch(10000);
      wait_done(n);
      check("t4_digits_10000", {bcd3, bcd2, bcd1, bcd0}, 32'h9999);
      check("t4_ovf_10000", overflow, 1);
      repeat (3) tick();
      check("t4_ovf_held", overflow, 1);
      launch(16383);
      wait_done(n);
      check("t4_digits_16383", {bcd3, bcd2, bcd1, bcd0}, 32'h9999);
      check("t4_ovf_16383", overflow, 1);
      launch(42);
      wait_done(n);
      check("t4_digits_42", {bcd3, bcd2, bcd1, bcd0}, 32'h0042);
      check("t4_ovf_42", overflow, 0);

      // 5: restart while busy is ignored
      launch(507);
      repeat (4) tick();
      start  = 1'b1;
      bin_in = 14'd8888;
      tick();
      start  = 1'b0;
      wait_done(n);
      check("t5_latency_rest", n, 9);
      check("t5_digits", {bcd3, bcd2, bcd1, bcd0}, 32'h0507);
      check("t5_ovf", overflow, 0);
      ndone = 0;
      repeat (20) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      check("t5_no_second_done", ndone, 0);

      // 6: reset mid-conversion
      launch(3141);
      repeat (6) tick();
      reset_n = 1'b0;
      #1;
      check("t6_rst_digits", {bcd3, bcd2, bcd1, bcd0}, 32'h0000);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #4 reset_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      check("t6_no_done", ndone, 0);
      launch(3141);
      wait_done(n);
      check("t6_digits", {bcd3, bcd2, bcd1, bcd0}, 32'h3141);

      // Spot sweep against the decimal model, including the clamp boundary
      foreach (sweep[i]) begin
         launch(sweep[i]);
         wait_done(n);
         check($sformatf("sweep_digits_%0d", sweep[i]), {bcd3, bcd2, bcd1, bcd0}, model(sweep[i]));
         check($sformatf("sweep_ovf_%0d", sweep[i]), overflow, (sweep[i] > 9999) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
